// File: rtl/lc3_control_unit.sv
// LC-3 instruction sequencer: fetch, decode and execute control for a
// multi-cycle datapath. Define ISDU_PAUSE_IR_EN to add a Continue handshake after each IR load.
module lc3_control_unit #(
  parameter int MEM_WAIT = 2,
  parameter int WAIT_W   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  // state     | meaning
  // HALTED    | idle until Run
  // FETCH     | MAR <- PC, PC <- PC+1
  // RD_WAIT   | SRAM read, MDR loaded on last cycle
  // LOAD_IR   | IR <- MDR
  // DECODE    | BEN load and opcode dispatch
  // ADD/AND/NOT | ALU result to register file
  // BR_TAKE   | PC <- PC + off9
  // JMP       | PC <- SR1
  // JSR1/JSR2 | R7 <- PC, then PC <- target
  // LDR1/LDR2 | MAR <- SR1+off6, read, DR <- MDR
  // STR1/STR2 | MAR <- SR1+off6, MDR <- SR, then write
  // WR_WAIT   | SRAM write
  // PAUSE_*   | LED load, Continue high-then-low handshake
  // PAUSE_IR* | optional handshake between LOAD_IR and DECODE
  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH,
    S_RD_WAIT,
    S_LOAD_IR,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR_TAKE,
    S_JMP,
    S_JSR1,
    S_JSR2,
    S_LDR1,
    S_LDR2,
    S_STR1,
    S_STR2,
    S_WR_WAIT,
    S_PAUSE_LED,
    S_PAUSE_HI,
    S_PAUSE_LO
`ifdef ISDU_PAUSE_IR_EN
    ,
    S_PAUSE_IR1,
    S_PAUSE_IR2
`endif
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ret_ldr_q, ret_ldr_d;
  logic              wait_done;

  assign wait_done = (wait_q == WAIT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_HALTED;
      wait_q    <= '0;
      ret_ldr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ret_ldr_q <= ret_ldr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    ret_ldr_d  = ret_ldr_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    unique case (state_q)
      S_HALTED: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        GatePC    = 1'b1;
        LD_MAR    = 1'b1;
        LD_PC     = 1'b1;
        PCMUX     = 2'b00;
        ret_ldr_d = 1'b0;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        Mem_OE = 1'b1;
        if (wait_done) begin
          LD_MDR  = 1'b1;
          wait_d  = '0;
          // The same read sequence serves instruction fetch and LDR.
          state_d = ret_ldr_q ? S_LDR2 : S_LOAD_IR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_LOAD_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
`ifdef ISDU_PAUSE_IR_EN
        state_d = S_PAUSE_IR1;
`else
        state_d = S_DECODE;
`endif
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        unique case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = BEN ? S_BR_TAKE : S_FETCH;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR1;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
          4'b1101: state_d = S_PAUSE_LED;
          default: state_d = S_FETCH;
        endcase
      end
      S_ADD: begin
        ALUK    = 2'b00;
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH;
      end
      S_AND: begin
        ALUK    = 2'b01;
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH;
      end
      S_NOT: begin
        ALUK    = 2'b10;
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH;
      end
      S_BR_TAKE: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        state_d  = S_FETCH;
      end
      S_JMP: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = 2'b00;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        state_d  = S_FETCH;
      end
      S_JSR1: begin
        GatePC  = 1'b1;
        DRMUX   = 1'b1;
        LD_REG  = 1'b1;
        state_d = S_JSR2;
      end
      S_JSR2: begin
        // IR_11 selects PC-relative JSR over register-based JSRR.
        ADDR1MUX = ~IR_11;
        ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        state_d  = S_FETCH;
      end
      S_LDR1: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ret_ldr_d  = 1'b1;
        state_d    = S_RD_WAIT;
      end
      S_LDR2: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH;
      end
      S_STR1: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_d    = S_STR2;
      end
      S_STR2: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        Mem_WE = 1'b1;
        if (wait_done) begin
          wait_d  = '0;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_PAUSE_LED: begin
        LD_LED  = 1'b1;
        state_d = S_PAUSE_HI;
      end
      S_PAUSE_HI: begin
        if (Continue) state_d = S_PAUSE_LO;
      end
      S_PAUSE_LO: begin
        if (!Continue) state_d = S_FETCH;
      end
`ifdef ISDU_PAUSE_IR_EN
      S_PAUSE_IR1: begin
        if (Continue) state_d = S_PAUSE_IR2;
      end
      S_PAUSE_IR2: begin
        if (!Continue) state_d = S_DECODE;
      end
`endif
      default: state_d = S_HALTED;
    endcase
  end

endmodule
